// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: CPU port, DMA port, shared RAM strobes and busy.
// slave = arbiter side, master = requesters plus RAM device side.
interface ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic [15:0] dma_rdata;
  logic        dma_ack;

  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic        ram_oe;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_addr, ram_wdata, ram_we, ram_oe, busy,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_addr, ram_wdata, ram_we, ram_oe, busy,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (CPU/DMA) arbiter and access sequencer for a single external RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; default is fixed CPU priority.
//
// state  | meaning
// IDLE   | sample requests, latch winner, load wait counter
// ACCESS | RAM strobes held from latches, counter runs down to 0
// DONE   | one-cycle ack to the owner, strobes low
module ram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          r,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic        owner_dma;
  logic [3:0]  cnt;
  logic [15:0] rd_reg;

  logic        any_req;
  logic        prefer_dma;
  logic        grant_dma;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

`ifdef RAM_ARB_RR_EN
  logic last_dma;
  assign prefer_dma = ~last_dma;
`else
  assign prefer_dma = 1'b0;
`endif

  assign any_req   = bus.cpu_req | bus.dma_req;
  assign grant_dma = bus.dma_req & (~bus.cpu_req | prefer_dma);
  assign sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
  assign sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;

  // Both ports present the shared read register.
  assign bus.cpu_rdata = rd_reg;
  assign bus.dma_rdata = rd_reg;

  // ram_we doubles as the latched write flag for the whole ACCESS phase.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state         <= IDLE;
      owner_dma     <= 1'b0;
      cnt           <= 4'd0;
      rd_reg        <= 16'h0000;
      bus.ram_addr  <= 16'h0000;
      bus.ram_wdata <= 16'h0000;
      bus.ram_we    <= 1'b0;
      bus.ram_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_dma      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dma     <= grant_dma;
            bus.ram_addr  <= sel_addr;
            bus.ram_wdata <= sel_wdata;
            bus.ram_we    <= sel_we;
            bus.ram_oe    <= ~sel_we;
            bus.busy      <= 1'b1;
            cnt           <= CNT_LOAD;
            state         <= ACCESS;
`ifdef RAM_ARB_RR_EN
            last_dma      <= grant_dma;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!bus.ram_we) rd_reg <= bus.ram_rdata;
            bus.ram_we  <= 1'b0;
            bus.ram_oe  <= 1'b0;
            bus.cpu_ack <= ~owner_dma;
            bus.dma_ack <= owner_dma;
            state       <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with WAIT_CYCLES=1, one with 3.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ram_arbiter;

  logic clk;
  logic r1;
  logic r3;
  int   n_vec;
  int   n_err;

  ram_arbiter_if b1 ();
  ram_arbiter_if b3 ();

  ram_arbiter #(.WAIT_CYCLES(1)) u1 (.clk(clk), .r(r1), .bus(b1));
  ram_arbiter #(.WAIT_CYCLES(3)) u3 (.clk(clk), .r(r3), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ram_model(input logic [15:0] a);
    return (a == 16'h8000) ? 16'h00A5 : (a ^ 16'h5A5A);
  endfunction

  assign b1.ram_rdata = ram_model(b1.ram_addr);
  assign b3.ram_rdata = ram_model(b3.ram_addr);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [4:0] exp_order;
    logic       e;
    logic [15:0] ea;
    int acks;
    n_vec = 0;
    n_err = 0;
    r1 = 1'b0;
    r3 = 1'b0;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = '0; b1.dma_wdata = '0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dma_req = 1'b0; b3.dma_we = 1'b0; b3.dma_addr = '0; b3.dma_wdata = '0;

    // Reset state
    cyc(2);
    check("rst_busy1", b1.busy, 1'b0);
    check("rst_we1", b1.ram_we, 1'b0);
    check("rst_oe1", b1.ram_oe, 1'b0);
    check("rst_addr1", b1.ram_addr, 16'h0000);
    check("rst_wdata1", b1.ram_wdata, 16'h0000);
    check("rst_acks1", {b1.cpu_ack, b1.dma_ack}, 2'b00);
    check("rst_rdata1", b1.cpu_rdata | b1.dma_rdata, 16'h0000);
    check("rst_busy3", b3.busy, 1'b0);
    r1 = 1'b1;
    r3 = 1'b1;
    cyc(3);
    check("idle_busy1", b1.busy, 1'b0);
    check("idle_strobes1", {b1.ram_we, b1.ram_oe}, 2'b00);
    check("idle_strobes3", {b3.ram_we, b3.ram_oe, b3.busy}, 3'b000);

    // CPU write, WAIT_CYCLES=1
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 16'h1234; b1.cpu_wdata = 16'hBEEF;
    cyc(1);
    check("wr_we", b1.ram_we, 1'b1);
    check("wr_oe", b1.ram_oe, 1'b0);
    check("wr_addr", b1.ram_addr, 16'h1234);
    check("wr_wdata", b1.ram_wdata, 16'hBEEF);
    check("wr_busy", b1.busy, 1'b1);
    check("wr_ack_early", b1.cpu_ack, 1'b0);
    cyc(1);
    check("wr_ack", b1.cpu_ack, 1'b1);
    check("wr_dma_ack", b1.dma_ack, 1'b0);
    check("wr_we_done", b1.ram_we, 1'b0);
    check("wr_busy_done", b1.busy, 1'b1);
    b1.cpu_req = 1'b0;
    cyc(1);
    check("wr_ack_once", b1.cpu_ack, 1'b0);
    check("wr_busy_idle", b1.busy, 1'b0);
    cyc(1);
    check("wr_no_regrant", b1.busy, 1'b0);

    // DMA read, WAIT_CYCLES=3
    b3.dma_req = 1'b1; b3.dma_we = 1'b0; b3.dma_addr = 16'h8000;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      check("rd_oe", b3.ram_oe, 1'b1);
      check("rd_we", b3.ram_we, 1'b0);
      check("rd_addr", b3.ram_addr, 16'h8000);
      check("rd_ack_early", b3.dma_ack, 1'b0);
    end
    cyc(1);
    check("rd_ack", b3.dma_ack, 1'b1);
    check("rd_data", b3.dma_rdata, 16'h00A5);
    check("rd_cpu_ack", b3.cpu_ack, 1'b0);
    check("rd_oe_done", b3.ram_oe, 1'b0);
    b3.dma_req = 1'b0;
    cyc(1);
    check("rd_ack_once", b3.dma_ack, 1'b0);
    check("rd_busy_idle", b3.busy, 1'b0);

    // Contention, WAIT_CYCLES=1, fresh reset so the CPU wins the first tie
    r1 = 1'b0;
    cyc(1);
    r1 = 1'b1;
`ifdef RAM_ARB_RR_EN
    exp_order = 5'b11010;
`else
    exp_order = 5'b10000;
`endif
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0100;
    b1.dma_req = 1'b1; b1.dma_we = 1'b0; b1.dma_addr = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      e  = exp_order[i];
      ea = e ? 16'h0200 : 16'h0100;
      cyc(1);
      check($sformatf("ct_addr%0d", i), b1.ram_addr, ea);
      check($sformatf("ct_oe%0d", i), b1.ram_oe, 1'b1);
      cyc(1);
      check($sformatf("ct_acks%0d", i), {b1.cpu_ack, b1.dma_ack}, {~e, e});
      check($sformatf("ct_rdata%0d", i), b1.cpu_rdata, ram_model(ea));
      if (i == 3) b1.cpu_req = 1'b0;
      if (i == 4) b1.dma_req = 1'b0;
      cyc(1);
      check($sformatf("ct_idle%0d", i), b1.busy, 1'b0);
    end
    cyc(1);
    check("ct_quiet", b1.busy, 1'b0);

    // Mid-access address change and req drop
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 16'h4000;
    cyc(1);
    check("mid_addr1", b3.ram_addr, 16'h4000);
    b3.cpu_addr = 16'h7777; b3.cpu_we = 1'b1; b3.cpu_req = 1'b0;
    acks = 0;
    for (int c = 2; c <= 8; c++) begin
      cyc(1);
      if (c <= 3) begin
        check("mid_addr", b3.ram_addr, 16'h4000);
        check("mid_strobes", {b3.ram_we, b3.ram_oe}, 2'b01);
      end
      if (c == 4) begin
        check("mid_ack", b3.cpu_ack, 1'b1);
        check("mid_rdata", b3.cpu_rdata, 16'h1A5A);
      end
      if (b3.cpu_ack) acks++;
    end
    check("mid_ack_count", 16'(acks), 16'd1);
    check("mid_busy_end", b3.busy, 1'b0);

    // Reset asserted mid-ACCESS
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b1; b3.cpu_addr = 16'h0055; b3.cpu_wdata = 16'h1111;
    cyc(1);
    check("mr_we_c1", b3.ram_we, 1'b1);
    cyc(1);
    r3 = 1'b0;
    #1;
    check("mr_we_drop", b3.ram_we, 1'b0);
    check("mr_busy_drop", b3.busy, 1'b0);
    check("mr_addr_clr", b3.ram_addr, 16'h0000);
    check("mr_rdata_clr", b3.cpu_rdata, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      cyc(1);
      check("mr_no_ack", b3.cpu_ack, 1'b0);
    end
    r3 = 1'b1;
    cyc(1);
    check("mr_regrant_we", b3.ram_we, 1'b1);
    check("mr_regrant_addr", b3.ram_addr, 16'h0055);
    check("mr_regrant_wdata", b3.ram_wdata, 16'h1111);
    cyc(3);
    check("mr_ack", b3.cpu_ack, 1'b1);
    b3.cpu_req = 1'b0;
    cyc(1);
    check("mr_ack_once", b3.cpu_ack, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
